exc_commit_ctrl: RTL and testbench



---
 rtl/exc_pkg.sv | 44 ++++
 rtl/exc_commit_ctrl_if.sv | 60 ++++++
 rtl/exc_prio_enc.sv | 39 +++
 rtl/exc_commit_ctrl.sv | 132 +++++++++++++
 tb/tb_exc_commit_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// Shared constants and types for the WB-stage exception/CSR commit controller.
// Holds LoongArch exception codes, CSR op encodings, the wb_exc bit positions,
// the controller FSM state enum and the priority-encoder result struct.
package exc_pkg;

  // Exception codes (ECODE) and subcodes (ESUBCODE)
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [8:0] ESUBCODE_NONE = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

  // Bit positions inside wb_exc = {ine, brk, sys, ale, adef}
  localparam int EXC_ADEF = 0;
  localparam int EXC_ALE  = 1;
  localparam int EXC_SYS  = 2;
  localparam int EXC_BRK  = 3;
  localparam int EXC_INE  = 4;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RD   = 2'd1,
    CSR_OP_WR   = 2'd2,
    CSR_OP_XCHG = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic       take;
    logic [5:0] ecode;
    logic [8:0] esubcode;
    logic       is_ertn;
  } prio_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Bundle of WB-stage, CSR-file and fetch-redirect signals of exc_commit_ctrl.
// master: the commit controller (drives CSR port, strobes, redirect request).
// slave : the surrounding pipeline / CSR file / fetch unit.
interface exc_commit_ctrl_if;
  // WB-stage instruction
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [4:0]  wb_exc;
  logic        wb_ertn;
  logic [1:0]  wb_csr_op;
  logic [13:0] wb_csr_num;
  logic [31:0] wb_csr_wdata;
  logic [31:0] wb_csr_mask;
  // Interrupt state from the CSR file
  logic [12:0] int_pending;
  logic        crmd_ie;
  // CSR read/write port
  logic [31:0] csr_rvalue;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        csr_re;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  // Exception / ertn strobes
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_vaddr;
  logic [5:0]  ex_ecode;
  logic [8:0]  ex_esubcode;
  logic        ertn_flush;
  // Retire
  logic        commit_valid;
  logic [31:0] rd_value;
  // Redirect handshake toward fetch
  logic        flush_valid;
  logic [31:0] flush_target;
  logic        flush_ack;

  modport master (
    input  wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn, wb_csr_op, wb_csr_num,
           wb_csr_wdata, wb_csr_mask, int_pending, crmd_ie, csr_rvalue,
           csr_eentry, csr_era, flush_ack,
    output wb_ready, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           ex_valid, ex_pc, ex_vaddr, ex_ecode, ex_esubcode, ertn_flush,
           commit_valid, rd_value, flush_valid, flush_target
  );

  modport slave (
    output wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn, wb_csr_op, wb_csr_num,
           wb_csr_wdata, wb_csr_mask, int_pending, crmd_ie, csr_rvalue,
           csr_eentry, csr_era, flush_ack,
    input  wb_ready, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           ex_valid, ex_pc, ex_vaddr, ex_ecode, ex_esubcode, ertn_flush,
           commit_valid, rd_value, flush_valid, flush_target
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder for a WB instruction's exception sources.
// Order: interrupt > adef > ine > brk > sys > ale; ertn only when nothing above.
// Ports: i_int_take, i_wb_exc {ine,brk,sys,ale,adef}, i_wb_ertn -> o_prio.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       i_int_take,
  input  logic [4:0] i_wb_exc,
  input  logic       i_wb_ertn,
  output prio_t      o_prio
);

  always_comb begin
    o_prio.take     = 1'b1;
    o_prio.ecode    = ECODE_INT;
    o_prio.esubcode = ESUBCODE_NONE;
    o_prio.is_ertn  = 1'b0;
    if (i_int_take) begin
      o_prio.ecode = ECODE_INT;
    end else if (i_wb_exc[EXC_ADEF]) begin
      o_prio.ecode    = ECODE_ADE;
      o_prio.esubcode = ESUBCODE_ADEF;
    end else if (i_wb_exc[EXC_INE]) begin
      o_prio.ecode = ECODE_INE;
    end else if (i_wb_exc[EXC_BRK]) begin
      o_prio.ecode = ECODE_BRK;
    end else if (i_wb_exc[EXC_SYS]) begin
      o_prio.ecode = ECODE_SYS;
    end else if (i_wb_exc[EXC_ALE]) begin
      o_prio.ecode = ECODE_ALE;
    end else begin
      // No exception: an ertn (if present) becomes the action
      o_prio.take    = 1'b0;
      o_prio.ecode   = 6'h00;
      o_prio.is_ertn = i_wb_ertn;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB/commit-point exception and CSR-access initiator toward the CSR file, with
// a flush/redirect handshake to fetch followed by a fixed wrong-path drain.
// Ports: clk, reset (sync, active-high), bus (exc_commit_ctrl_if.master).
// Optional: define EXC_INT_EN to enable interrupt sampling (else int_take=0).
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h1c000000
) (
  input  logic                clk,
  input  logic                reset,
  exc_commit_ctrl_if.master   bus
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_drain_cnt;
  logic [3:0]  w_drain_cnt_nxt;
  logic [31:0] r_flush_target;
  logic [31:0] w_flush_target_nxt;

  logic        w_run;
  logic        w_accept;
  logic        w_int_take;
  prio_t       w_prio;
  logic        w_exc_take;
  logic        w_ertn_take;
  logic        w_commit;
  logic        w_csr_take;
  logic        w_csr_write;

  assign w_run = (r_state == ST_RUN);
  // Reset gates the accept so no strobe can fire while reset is held
  assign w_accept = bus.wb_valid & w_run & ~reset;

`ifdef EXC_INT_EN
  assign w_int_take = bus.crmd_ie & (|bus.int_pending) & w_accept;
`else
  logic w_unused_int;
  assign w_int_take   = 1'b0;
  assign w_unused_int = bus.crmd_ie ^ (|bus.int_pending);
`endif

  exc_prio_enc u_prio (
    .i_int_take (w_int_take),
    .i_wb_exc   (bus.wb_exc),
    .i_wb_ertn  (bus.wb_ertn),
    .o_prio     (w_prio)
  );

  assign w_exc_take  = w_accept & w_prio.take;
  assign w_ertn_take = w_accept & w_prio.is_ertn;
  assign w_commit    = w_accept & ~w_prio.take & ~w_prio.is_ertn;
  assign w_csr_take  = w_commit & (bus.wb_csr_op != CSR_OP_NONE);
  assign w_csr_write = w_csr_take &
                       ((bus.wb_csr_op == CSR_OP_WR) | (bus.wb_csr_op == CSR_OP_XCHG));

  // WB handshake / retire
  assign bus.wb_ready     = w_run;
  assign bus.commit_valid = w_commit;
  assign bus.rd_value     = bus.csr_rvalue;

  // CSR port: read data returns in the same cycle as csr_re
  assign bus.csr_re     = w_csr_take;
  assign bus.csr_num    = bus.wb_csr_num;
  assign bus.csr_we     = w_csr_write;
  assign bus.csr_wvalue = bus.wb_csr_wdata;
  assign bus.csr_wmask  = (bus.wb_csr_op == CSR_OP_XCHG) ? bus.wb_csr_mask :
                          (bus.wb_csr_op == CSR_OP_WR)   ? 32'hffffffff   : 32'h0;

  // Exception / ertn strobes
  assign bus.ex_valid    = w_exc_take;
  assign bus.ex_pc       = bus.wb_pc;
  assign bus.ex_vaddr    = bus.wb_vaddr;
  assign bus.ex_ecode    = w_exc_take ? w_prio.ecode    : 6'h00;
  assign bus.ex_esubcode = w_exc_take ? w_prio.esubcode : 9'h000;
  assign bus.ertn_flush  = w_ertn_take;

  // Redirect
  assign bus.flush_valid  = (r_state == ST_FLUSH);
  assign bus.flush_target = r_flush_target;

  always_comb begin
    w_state_nxt        = r_state;
    w_drain_cnt_nxt    = r_drain_cnt;
    w_flush_target_nxt = r_flush_target;
    case (r_state)
      ST_RUN: begin
        if (w_exc_take) begin
          w_flush_target_nxt = bus.csr_eentry;
          w_state_nxt        = ST_FLUSH;
        end else if (w_ertn_take) begin
          // ERA as seen before any update by this ertn
          w_flush_target_nxt = bus.csr_era;
          w_state_nxt        = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (bus.flush_ack) begin
          w_drain_cnt_nxt = DRAIN_INIT;
          w_state_nxt     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == 4'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_drain_cnt    <= 4'd0;
      r_flush_target <= RESET_PC;
    end else begin
      r_state        <= w_state_nxt;
      r_drain_cnt    <= w_drain_cnt_nxt;
      r_flush_target <= w_flush_target_nxt;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed vector table, hand-written
// flush/drain/reset sequences, and randomized traffic against a reference model.
module tb_exc_commit_ctrl;
  import exc_pkg::*;

  localparam int          DRAIN  = 2;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam logic [31:0] EENTRY = 32'h1c008000;
  localparam logic [31:0] ERA    = 32'h1c000100;
`ifdef EXC_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_commit_ctrl_if bus();

  exc_commit_ctrl #(.DRAIN_CYCLES(DRAIN), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid     = 1'b0;
    bus.wb_pc        = 32'h1c000040;
    bus.wb_vaddr     = 32'h1c000003;
    bus.wb_exc       = 5'b0;
    bus.wb_ertn      = 1'b0;
    bus.wb_csr_op    = 2'd0;
    bus.wb_csr_num   = 14'h30;
    bus.wb_csr_wdata = 32'h12345678;
    bus.wb_csr_mask  = 32'h0000ff00;
    bus.int_pending  = 13'h0;
    bus.crmd_ie      = 1'b0;
    bus.csr_rvalue   = 32'hdeadbeef;
    bus.csr_eentry   = EENTRY;
    bus.csr_era      = ERA;
    bus.flush_ack    = 1'b0;
  endtask

  // Walks a pending redirect: hold for 'hold' cycles with wrong-path WB traffic,
  // ack it, then expect DRAIN blocked cycles before wb_ready returns.
  task automatic finish_flush(input string tag, input logic [31:0] target, input int hold);
    bus.wb_valid  = 1'b1;
    bus.wb_csr_op = 2'd2;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".flush_valid"}, 32'(bus.flush_valid), 32'd1);
      chk({tag, ".flush_target"}, bus.flush_target, target);
      chk({tag, ".flush_nocommit"}, 32'({bus.commit_valid, bus.csr_we, bus.wb_ready}), 32'd0);
      tick();
    end
    bus.flush_ack = 1'b1;
    @(negedge clk);
    chk({tag, ".ack_cycle_valid"}, 32'(bus.flush_valid), 32'd1);
    tick();
    bus.flush_ack = 1'b0;
    for (int d = 0; d < DRAIN; d++) begin
      @(negedge clk);
      chk({tag, ".drain_ready"}, 32'(bus.wb_ready), 32'd0);
      chk({tag, ".drain_quiet"}, 32'({bus.flush_valid, bus.commit_valid, bus.ex_valid}), 32'd0);
      tick();
    end
    bus.wb_valid  = 1'b0;
    bus.wb_csr_op = 2'd0;
    @(negedge clk);
    chk({tag, ".ready_after_drain"}, 32'(bus.wb_ready), 32'd1);
    tick();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  exc;
    logic        ertn;
    logic [31:0] pc;
    logic        exp_ex;
    logic [5:0]  exp_ecode;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_wmask;
    logic        exp_commit;
    logic        exp_ertn;
    logic [31:0] exp_target;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [4:0] exc, input logic ertn,
                              input logic [31:0] pc, input logic ex, input logic [5:0] ec,
                              input logic re, input logic we, input logic [31:0] wm,
                              input logic cm, input logic er, input logic [31:0] tg);
    vec_t v;
    v.op = op; v.exc = exc; v.ertn = ertn; v.pc = pc;
    v.exp_ex = ex; v.exp_ecode = ec; v.exp_re = re; v.exp_we = we; v.exp_wmask = wm;
    v.exp_commit = cm; v.exp_ertn = er; v.exp_target = tg;
    return v;
  endfunction

  vec_t vecs[12];

  // Reference-model state for the random phase
  bit          m_flush;
  int          m_drain;
  logic [31:0] m_target;

  initial begin
    string tag;
    //             op    exc       ertn pc            ex ecode  re we wmask         cm er target
    vecs[0]  = mk(2'd3, 5'b00000, 1'b0, 32'h1c000040, 0, 6'h00, 1, 1, 32'h0000ff00, 1, 0, 0);
    vecs[1]  = mk(2'd1, 5'b00000, 1'b0, 32'h1c000044, 0, 6'h00, 1, 0, 32'h0,        1, 0, 0);
    vecs[2]  = mk(2'd2, 5'b00000, 1'b0, 32'h1c000048, 0, 6'h00, 1, 1, 32'hffffffff, 1, 0, 0);
    vecs[3]  = mk(2'd0, 5'b00000, 1'b0, 32'h1c00004c, 0, 6'h00, 0, 0, 32'h0,        1, 0, 0);
    vecs[4]  = mk(2'd0, 5'b00100, 1'b0, 32'h1c000040, 1, 6'h0B, 0, 0, 32'h0,        0, 0, EENTRY);
    vecs[5]  = mk(2'd0, 5'b00011, 1'b0, 32'h1c000003, 1, 6'h08, 0, 0, 32'h0,        0, 0, EENTRY);
    vecs[6]  = mk(2'd2, 5'b11100, 1'b0, 32'h1c000050, 1, 6'h0D, 0, 0, 32'h0,        0, 0, EENTRY);
    vecs[7]  = mk(2'd0, 5'b01100, 1'b0, 32'h1c000054, 1, 6'h0C, 0, 0, 32'h0,        0, 0, EENTRY);
    vecs[8]  = mk(2'd2, 5'b00010, 1'b0, 32'h1c000058, 1, 6'h09, 0, 0, 32'h0,        0, 0, EENTRY);
    vecs[9]  = mk(2'd0, 5'b00000, 1'b1, 32'h1c00005c, 0, 6'h00, 0, 0, 32'h0,        0, 1, ERA);
    vecs[10] = mk(2'd0, 5'b00100, 1'b1, 32'h1c000060, 1, 6'h0B, 0, 0, 32'h0,        0, 0, EENTRY);
    vecs[11] = mk(2'd3, 5'b00000, 1'b1, 32'h1c000064, 0, 6'h00, 0, 0, 32'h0,        0, 1, ERA);

    // ---- reset state (strobes stay low even with a request present) ----
    idle_inputs();
    reset = 1'b1;
    tick();
    bus.wb_valid  = 1'b1;
    bus.wb_csr_op = 2'd2;
    bus.wb_exc    = 5'b00100;
    @(negedge clk);
    chk("rst.strobes", 32'({bus.csr_re, bus.csr_we, bus.ex_valid, bus.ertn_flush, bus.commit_valid}), 32'd0);
    chk("rst.flush_valid", 32'(bus.flush_valid), 32'd0);
    chk("rst.flush_target", bus.flush_target, RST_PC);
    chk("rst.wb_ready", 32'(bus.wb_ready), 32'd1);
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();

    // ---- directed vector table ----
    for (int i = 0; i < 12; i++) begin
      tag = $sformatf("vec%0d", i);
      bus.wb_valid  = 1'b1;
      bus.wb_csr_op = vecs[i].op;
      bus.wb_exc    = vecs[i].exc;
      bus.wb_ertn   = vecs[i].ertn;
      bus.wb_pc     = vecs[i].pc;
      @(negedge clk);
      chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(vecs[i].exp_ex));
      chk({tag, ".ecode"}, 32'(bus.ex_ecode), 32'(vecs[i].exp_ecode));
      chk({tag, ".esubcode"}, 32'(bus.ex_esubcode), 32'd0);
      chk({tag, ".csr_re"}, 32'(bus.csr_re), 32'(vecs[i].exp_re));
      chk({tag, ".csr_we"}, 32'(bus.csr_we), 32'(vecs[i].exp_we));
      chk({tag, ".commit"}, 32'(bus.commit_valid), 32'(vecs[i].exp_commit));
      chk({tag, ".ertn_flush"}, 32'(bus.ertn_flush), 32'(vecs[i].exp_ertn));
      if (vecs[i].exp_we) begin
        chk({tag, ".wmask"}, bus.csr_wmask, vecs[i].exp_wmask);
        chk({tag, ".wvalue"}, bus.csr_wvalue, 32'h12345678);
      end
      if (vecs[i].exp_re) begin
        chk({tag, ".csr_num"}, 32'(bus.csr_num), 32'h30);
        chk({tag, ".rd_value"}, bus.rd_value, 32'hdeadbeef);
      end
      if (vecs[i].exp_ex) begin
        chk({tag, ".ex_pc"}, bus.ex_pc, vecs[i].pc);
        chk({tag, ".ex_vaddr"}, bus.ex_vaddr, 32'h1c000003);
      end
      tick();
      idle_inputs();
      if (vecs[i].exp_ex || vecs[i].exp_ertn) begin
        finish_flush(tag, vecs[i].exp_target, (i == 4) ? 3 : 1);
      end else begin
        @(negedge clk);
        chk({tag, ".ready_kept"}, 32'(bus.wb_ready), 32'd1);
        chk({tag, ".no_flush"}, 32'(bus.flush_valid), 32'd0);
        tick();
      end
    end

    // ---- interrupt with concurrent csrwr ----
    bus.wb_valid    = 1'b1;
    bus.wb_csr_op   = 2'd2;
    bus.crmd_ie     = 1'b1;
    bus.int_pending = 13'h800;
    @(negedge clk);
    chk("int.ex_valid", 32'(bus.ex_valid), 32'(INT_EN));
    chk("int.csr_we", 32'(bus.csr_we), 32'(!INT_EN));
    if (INT_EN) chk("int.ecode", 32'(bus.ex_ecode), 32'h00);
    tick();
    idle_inputs();
    if (INT_EN) finish_flush("int", EENTRY, 1);
    bus.wb_valid    = 1'b1;
    bus.wb_csr_op   = 2'd2;
    bus.crmd_ie     = 1'b0;
    bus.int_pending = 13'h800;
    @(negedge clk);
    chk("int_off.ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("int_off.csr_we", 32'(bus.csr_we), 32'd1);
    chk("int_off.commit", 32'(bus.commit_valid), 32'd1);
    tick();
    idle_inputs();

    // ---- flush_ack outside FLUSH is ignored ----
    bus.wb_valid  = 1'b1;
    bus.flush_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack.commit", 32'(bus.commit_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("stray_ack.ready", 32'(bus.wb_ready), 32'd1);
    chk("stray_ack.flush_valid", 32'(bus.flush_valid), 32'd0);
    tick();
    idle_inputs();

    // ---- reset while in FLUSH ----
    bus.wb_valid = 1'b1;
    bus.wb_exc   = 5'b00100;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rst_flush.pre_valid", 32'(bus.flush_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_flush.flush_valid", 32'(bus.flush_valid), 32'd0);
    chk("rst_flush.wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("rst_flush.target", bus.flush_target, RST_PC);
    tick();

    // ---- randomized traffic vs reference model ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_flush  = 1'b0;
    m_drain  = 0;
    m_target = RST_PC;
    for (int n = 0; n < 600; n++) begin
      bit ready, acc, intr, exc_any, ertn_any, normal, csr, we;
      logic [5:0] ecode;
      logic [4:0] e;
      bus.wb_valid     = 1'($urandom_range(0, 1));
      bus.wb_csr_op    = 2'($urandom_range(0, 3));
      bus.wb_exc       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      bus.wb_ertn      = ($urandom_range(0, 7) == 0);
      bus.wb_pc        = $urandom;
      bus.wb_vaddr     = $urandom;
      bus.wb_csr_num   = 14'($urandom);
      bus.wb_csr_wdata = $urandom;
      bus.wb_csr_mask  = $urandom;
      bus.csr_rvalue   = $urandom;
      bus.csr_eentry   = $urandom;
      bus.csr_era      = $urandom;
      bus.crmd_ie      = 1'($urandom_range(0, 1));
      bus.int_pending  = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'h0;
      bus.flush_ack    = ($urandom_range(0, 2) == 0);
      reset            = ($urandom_range(0, 60) == 0);

      e        = bus.wb_exc;
      ready    = !m_flush && (m_drain == 0);
      acc      = bus.wb_valid && ready && !reset;
      intr     = INT_EN && bus.crmd_ie && (bus.int_pending != 0);
      exc_any  = acc && (intr || (e != 0));
      ecode    = intr ? 6'h00 : e[0] ? 6'h08 : e[4] ? 6'h0D : e[3] ? 6'h0C : e[2] ? 6'h0B : 6'h09;
      ertn_any = acc && !exc_any && bus.wb_ertn;
      normal   = acc && !exc_any && !bus.wb_ertn;
      csr      = normal && (bus.wb_csr_op != 2'd0);
      we       = csr && (bus.wb_csr_op >= 2'd2);

      @(negedge clk);
      chk("rnd.wb_ready", 32'(bus.wb_ready), 32'(ready));
      chk("rnd.ex_valid", 32'(bus.ex_valid), 32'(exc_any));
      chk("rnd.ertn_flush", 32'(bus.ertn_flush), 32'(ertn_any));
      chk("rnd.commit", 32'(bus.commit_valid), 32'(normal));
      chk("rnd.csr_re", 32'(bus.csr_re), 32'(csr));
      chk("rnd.csr_we", 32'(bus.csr_we), 32'(we));
      chk("rnd.flush_valid", 32'(bus.flush_valid), 32'(m_flush));
      chk("rnd.flush_target", bus.flush_target, m_target);
      if (exc_any) begin
        chk("rnd.ecode", 32'(bus.ex_ecode), 32'(ecode));
        chk("rnd.ex_pc", bus.ex_pc, bus.wb_pc);
      end
      if (we) begin
        chk("rnd.wmask", bus.csr_wmask, (bus.wb_csr_op == 2'd3) ? bus.wb_csr_mask : 32'hffffffff);
        chk("rnd.wvalue", bus.csr_wvalue, bus.wb_csr_wdata);
      end
      if (csr) chk("rnd.rd_value", bus.rd_value, bus.csr_rvalue);

      @(posedge clk);
      if (reset) begin
        m_flush = 1'b0; m_drain = 0; m_target = RST_PC;
      end else if (m_flush) begin
        if (bus.flush_ack) begin m_flush = 1'b0; m_drain = DRAIN; end
      end else if (m_drain > 0) begin
        m_drain--;
      end else if (exc_any) begin
        m_flush = 1'b1; m_target = bus.csr_eentry;
      end else if (ertn_any) begin
        m_flush = 1'b1; m_target = bus.csr_era;
      end
      #1;
    end
    reset = 1'b0;
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
